// File: rtl/circuito_jogo_param.sv
// circuito_jogo_param: memory-matching game (control, datapath and ROM in one module).
// Define CIRCUITO_JOGO_TIMEOUT_EN to enable the ESPERA timeout that ends a game in error.
module circuito_jogo_param #(
   parameter int WIDTH          = 4,
   parameter int DEPTH          = 16,
   parameter int ADDR_W         = $clog2(DEPTH),
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              jogada,
   input  logic [WIDTH-1:0]  chaves,
   input  logic [ADDR_W-1:0] limite,
   output logic              pronto,
   output logic              acertou,
   output logic              errou,
   output logic              db_igual,
   output logic [ADDR_W-1:0] db_contagem,
   output logic [WIDTH-1:0]  db_memoria,
   output logic [WIDTH-1:0]  db_chaves,
   output logic [3:0]        db_estado,
   output logic              db_timeout
);

   typedef enum logic [3:0] {
      INICIAL    = 4'd0,
      PREPARACAO = 4'd1,
      ESPERA     = 4'd2,
      REGISTRA   = 4'd4,
      COMPARA    = 4'd5,
      PROXIMO    = 4'd6,
      FIM_ACERTO = 4'd10,
      FIM_ERRO   = 4'd14
   } estado_t;

   estado_t           estado;
   estado_t           proximo_estado;
   logic [ADDR_W-1:0] endereco;
   logic [ADDR_W-1:0] limite_reg;
   logic [WIDTH-1:0]  chaves_reg;
   logic [WIDTH-1:0]  palavra;
   logic              jogada_q;
   logic              jogada_borda;
   logic              fim_tempo;

   // Fixed ROM: a single walking one, repeating every WIDTH words.
   logic [WIDTH-1:0] rom [DEPTH];
   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      assign rom[i] = WIDTH'(1) << (i % WIDTH);
   end

   assign palavra      = rom[endereco];
   assign jogada_borda = jogada & ~jogada_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= INICIAL;
      end else begin
         estado <= proximo_estado;
      end
   end

   always_comb begin
      proximo_estado = estado;
      case (estado)
         INICIAL:    if (iniciar) proximo_estado = PREPARACAO;
         PREPARACAO: proximo_estado = ESPERA;
         ESPERA: begin
            if (jogada_borda)   proximo_estado = REGISTRA;
            else if (fim_tempo) proximo_estado = FIM_ERRO;
         end
         REGISTRA:   proximo_estado = COMPARA;
         COMPARA: begin
            if (!db_igual)                    proximo_estado = FIM_ERRO;
            else if (endereco == limite_reg)  proximo_estado = FIM_ACERTO;
            else                              proximo_estado = PROXIMO;
         end
         PROXIMO:    proximo_estado = ESPERA;
         FIM_ACERTO: if (iniciar) proximo_estado = PREPARACAO;
         FIM_ERRO:   if (iniciar) proximo_estado = PREPARACAO;
         default:    proximo_estado = INICIAL;
      endcase
   end

   // Edge register resets to 1 so a jogada held through reset release is not a move.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         endereco   <= '0;
         limite_reg <= '0;
         chaves_reg <= '0;
         jogada_q   <= 1'b1;
      end else begin
         jogada_q <= jogada;
         case (estado)
            PREPARACAO: begin
               endereco   <= '0;
               chaves_reg <= '0;
               limite_reg <= limite;
            end
            REGISTRA: chaves_reg <= chaves;
            PROXIMO:  if (endereco != limite_reg) endereco <= endereco + ADDR_W'(1);
            default:  ;
         endcase
      end
   end

`ifdef CIRCUITO_JOGO_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] contador_tempo;
   logic          timeout_reg;

   assign fim_tempo = (estado == ESPERA) && (contador_tempo == TW'(TIMEOUT_CYCLES - 1));

   // A move arriving in the expiry cycle wins, so the flag only sets without one.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         contador_tempo <= '0;
         timeout_reg    <= 1'b0;
      end else begin
         if (estado == ESPERA) contador_tempo <= contador_tempo + TW'(1);
         else                  contador_tempo <= '0;
         if (estado == PREPARACAO)           timeout_reg <= 1'b0;
         else if (fim_tempo && !jogada_borda) timeout_reg <= 1'b1;
      end
   end

   assign db_timeout = timeout_reg;
`else
   assign fim_tempo  = 1'b0;
   assign db_timeout = 1'b0;
`endif

   assign pronto      = (estado == FIM_ACERTO) || (estado == FIM_ERRO);
   assign acertou     = (estado == FIM_ACERTO);
   assign errou       = (estado == FIM_ERRO);
   assign db_igual    = (chaves_reg == palavra);
   assign db_contagem = endereco;
   assign db_memoria  = palavra;
   assign db_chaves   = chaves_reg;
   assign db_estado   = estado;

endmodule

// File: tb/tb_circuito_jogo_param.sv
// tb_circuito_jogo_param: vector table, hand-written corner sequences and random games
// checked against a game-rule model of circuito_jogo_param.
module tb_circuito_jogo_param;

   localparam int WIDTH  = 4;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clock   = 1'b0;
   logic              reset   = 1'b1;
   logic              iniciar = 1'b0;
   logic              jogada  = 1'b0;
   logic [WIDTH-1:0]  chaves  = '0;
   logic [ADDR_W-1:0] limite  = '0;
   logic              pronto, acertou, errou, db_igual, db_timeout;
   logic [ADDR_W-1:0] db_contagem;
   logic [WIDTH-1:0]  db_memoria, db_chaves;
   logic [3:0]        db_estado;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic [3:0]  lim;
      int          n;
      logic [63:0] moves;
      logic [3:0]  expEstado;
      logic [3:0]  expCont;
      logic [3:0]  expChaves;
      logic [3:0]  expMem;
   } vec_t;

   vec_t vecs[6];

   circuito_jogo_param #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .iniciar(iniciar),
      .jogada(jogada),
      .chaves(chaves),
      .limite(limite),
      .pronto(pronto),
      .acertou(acertou),
      .errou(errou),
      .db_igual(db_igual),
      .db_contagem(db_contagem),
      .db_memoria(db_memoria),
      .db_chaves(db_chaves),
      .db_estado(db_estado),
      .db_timeout(db_timeout)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // One move: jogada high for `hold` cycles, then low long enough for the move to settle.
   task automatic applyStimulus(input logic [3:0] v, input int hold);
      chaves = v;
      jogada = 1'b1;
      repeat (hold) tick();
      jogada = 1'b0;
      tick();
      if (hold < 3) repeat (3 - hold) tick();
   endtask

   task automatic startGame(input logic [3:0] lim);
      limite  = lim;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
   endtask

   function automatic logic [3:0] romWord(input int i);
      return 4'(1 << (i % WIDTH));
   endfunction

   // Game rules: a wrong key ends in error at its index, a right key at the limit ends in success.
   task automatic checkMove(input string name, input int idx, input logic [3:0] v,
                            input int lim, output bit ended);
      int es;
      int ad;
      if (v != romWord(idx))  begin es = 14; ad = idx;     end
      else if (idx == lim)    begin es = 10; ad = lim;     end
      else                    begin es = 2;  ad = idx + 1; end
      checkOutput({name, " estado"}, int'(db_estado), es);
      checkOutput({name, " contagem"}, int'(db_contagem), ad);
      ended = (es != 2);
      if (ended) begin
         checkOutput({name, " chaves"}, int'(db_chaves), int'(v));
         checkOutput({name, " errou"}, int'(errou), (es == 14) ? 1 : 0);
      end
   endtask

   initial begin
      bit         ended;
      int         lim;
      int         idx;
      logic [3:0] v;

      vecs[0] = '{4'd3, 4, 64'h8421,   4'd10, 4'd3, 4'd8, 4'd8};
      vecs[1] = '{4'd3, 2, 64'h41,     4'd14, 4'd1, 4'd4, 4'd2};
      vecs[2] = '{4'd0, 1, 64'h1,      4'd10, 4'd0, 4'd1, 4'd1};
      vecs[3] = '{4'd0, 1, 64'h2,      4'd14, 4'd0, 4'd2, 4'd1};
      vecs[4] = '{4'd5, 6, 64'h218421, 4'd10, 4'd5, 4'd2, 4'd2};
      vecs[5] = '{4'd2, 3, 64'h021,    4'd14, 4'd2, 4'd0, 4'd4};

      // Reset with jogada held high through release
      #1 reset = 1'b0;
      jogada = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      checkOutput("reset estado", int'(db_estado), 0);
      checkOutput("reset pronto", int'(pronto), 0);
      checkOutput("reset acertou", int'(acertou), 0);
      checkOutput("reset errou", int'(errou), 0);
      checkOutput("reset contagem", int'(db_contagem), 0);
      checkOutput("reset memoria", int'(db_memoria), 1);
      checkOutput("reset chaves", int'(db_chaves), 0);
      checkOutput("reset igual", int'(db_igual), 0);
      checkOutput("reset timeout", int'(db_timeout), 0);

      startGame(4'd3);
      tick();
      tick();
      checkOutput("held jogada estado", int'(db_estado), 2);
      jogada = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(romWord(i), 1);
         checkMove("basic game", i, romWord(i), 3, ended);
      end
      checkOutput("basic game pronto", int'(pronto), 1);
      checkOutput("basic game acertou", int'(acertou), 1);

      // Vector table
      for (int k = 0; k < 6; k++) begin
         startGame(vecs[k].lim);
         for (int i = 0; i < vecs[k].n; i++) applyStimulus(vecs[k].moves[4*i +: 4], 1);
         checkOutput($sformatf("vec%0d estado", k), int'(db_estado), int'(vecs[k].expEstado));
         checkOutput($sformatf("vec%0d contagem", k), int'(db_contagem), int'(vecs[k].expCont));
         checkOutput($sformatf("vec%0d chaves", k), int'(db_chaves), int'(vecs[k].expChaves));
         checkOutput($sformatf("vec%0d memoria", k), int'(db_memoria), int'(vecs[k].expMem));
         checkOutput($sformatf("vec%0d pronto", k), int'(pronto), 1);
         checkOutput($sformatf("vec%0d acertou", k), int'(acertou), (vecs[k].expEstado == 4'd10) ? 1 : 0);
         checkOutput($sformatf("vec%0d igual", k), int'(db_igual), (vecs[k].expEstado == 4'd10) ? 1 : 0);
      end

      // Full ROM with cycle-exact latency on the first move and a long held jogada
      limite  = 4'd15;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      checkOutput("latency preparacao", int'(db_estado), 1);
      tick();
      checkOutput("latency espera", int'(db_estado), 2);
      chaves = 4'd1;
      jogada = 1'b1;
      tick();
      checkOutput("latency registra", int'(db_estado), 4);
      jogada = 1'b0;
      tick();
      checkOutput("latency compara", int'(db_estado), 5);
      tick();
      checkOutput("latency proximo", int'(db_estado), 6);
      tick();
      checkMove("latency back to espera", 0, 4'd1, 15, ended);
      for (int i = 1; i < 16; i++) begin
         applyStimulus(romWord(i), (i == 3) ? 5 : 1);
         checkMove($sformatf("full rom move%0d", i), i, romWord(i), 15, ended);
      end
      checkOutput("full rom acertou", int'(acertou), 1);

      // Limite change mid-game and iniciar outside FIM are both ignored
      startGame(4'd1);
      applyStimulus(4'd1, 1);
      limite  = 4'd5;
      iniciar = 1'b1;
      tick();
      tick();
      iniciar = 1'b0;
      checkOutput("iniciar ignored estado", int'(db_estado), 2);
      checkOutput("iniciar ignored contagem", int'(db_contagem), 1);
      applyStimulus(4'd2, 1);
      checkMove("limite change", 1, 4'd2, 1, ended);

      // Asynchronous reset between clock edges
      startGame(4'd7);
      applyStimulus(4'd1, 1);
      applyStimulus(4'd2, 1);
      checkOutput("pre-reset contagem", int'(db_contagem), 2);
      #3 reset = 1'b0;
      #1;
      checkOutput("async reset estado", int'(db_estado), 0);
      checkOutput("async reset contagem", int'(db_contagem), 0);
      checkOutput("async reset chaves", int'(db_chaves), 0);
      checkOutput("async reset memoria", int'(db_memoria), 1);
      checkOutput("async reset pronto", int'(pronto), 0);
      tick();
      reset = 1'b1;
      tick();
      checkOutput("after reset estado", int'(db_estado), 0);
      startGame(4'd3);
      checkOutput("restart estado", int'(db_estado), 2);
      checkOutput("restart contagem", int'(db_contagem), 0);
      applyStimulus(4'd1, 1);
      checkMove("restart move0", 0, 4'd1, 3, ended);
      applyStimulus(4'd0, 1);
      checkMove("restart move1", 1, 4'd0, 3, ended);

      // Timeout in ESPERA
      startGame(4'd3);
      checkOutput("timeout cleared", int'(db_timeout), 0);
`ifdef CIRCUITO_JOGO_TIMEOUT_EN
      repeat (7) tick();
      checkOutput("timeout pre-expiry estado", int'(db_estado), 2);
      tick();
      checkOutput("timeout estado", int'(db_estado), 14);
      checkOutput("timeout errou", int'(errou), 1);
      checkOutput("timeout flag", int'(db_timeout), 1);
      startGame(4'd3);
      checkOutput("timeout flag cleared", int'(db_timeout), 0);
      repeat (7) tick();
      applyStimulus(4'd1, 1);
      checkMove("move beats timeout", 0, 4'd1, 3, ended);
      checkOutput("move beats timeout flag", int'(db_timeout), 0);
      applyStimulus(4'd4, 1);
      checkMove("after timeout race", 1, 4'd4, 3, ended);
      checkOutput("mismatch not timeout", int'(db_timeout), 0);
`else
      repeat (20) tick();
      checkOutput("no timeout estado", int'(db_estado), 2);
      checkOutput("no timeout flag", int'(db_timeout), 0);
      checkOutput("no timeout contagem", int'(db_contagem), 0);
      applyStimulus(4'd0, 1);
      checkMove("no timeout exit", 0, 4'd0, 3, ended);
`endif

      // Random games against the rule model
      for (int g = 0; g < 40; g++) begin
         lim   = int'($urandom_range(0, 15));
         idx   = 0;
         ended = 1'b0;
         startGame(4'(lim));
         while (!ended && idx < 16) begin
            v = romWord(idx);
            if ($urandom_range(0, 99) < 10) v = v ^ 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) limite = 4'($urandom);
            applyStimulus(v, int'($urandom_range(1, 3)));
            checkMove($sformatf("rand g%0d m%0d", g, idx), idx, v, lim, ended);
            idx++;
         end
         checkOutput($sformatf("rand g%0d pronto", g), int'(pronto), 1);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/circuito_jogo_param.md
Name: circuito_jogo_param

Overview:
- Parametrised successor of the single-pass "chaves vs memoria" top level.
- Walks an internal ROM of DEPTH words, each WIDTH bits wide.
- Each player move is signalled by a rising edge on `jogada`. On each move the block registers `chaves` and compares it with the current ROM word. A mismatch ends in error; a match on the last selected position ends in success.
- The sequence length is selectable per game through `limite`. Control unit, datapath and ROM live inside one module; the 7-seg displays stay at board level.

Parameters:
- WIDTH, 4: width of `chaves` and of each ROM word.
- DEPTH, 16: number of ROM words; must be a power of 2, ≥2.
- ADDR_W, $clog2(DEPTH): width of the address counter (derived; do not override).
- TIMEOUT_CYCLES, 5000: cycles allowed in ESPERA before timeout. Used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- iniciar  in  1  start request, level-sampled.
- jogada  in  1  move strobe; only rising edges count.
- chaves  in  WIDTH  player input.
- limite  in  ADDR_W  last position to check in this game (length = limite+1).
- pronto  out  1  game finished.
- acertou  out  1  game ended with all positions matched.
- errou  out  1  game ended in mismatch or timeout.
- db_igual  out  1  combinational: registered chaves == mem[addr].
- db_contagem  out  ADDR_W  current address.
- db_memoria  out  WIDTH  mem[addr].
- db_chaves  out  WIDTH  registered chaves.
- db_estado  out  4  state code.
- db_timeout  out  1  game ended by timeout.

Behaviour:
- ROM content is fixed: mem[i] = 1 << (i mod WIDTH), giving 1, 2, 4, 8, 1, … for WIDTH=4.
- Reset (reset=0, async) forces:
  - state INICIAL (code 0);
  - address 0, chaves register 0, limite register 0;
  - all outputs 0 except db_memoria = mem[0];
  - the jogada edge register to 1, so a `jogada` held high through reset release is not a move.
- Edge detect: `jogada_q` registers `jogada` every cycle. A move is jogada & ~jogada_q. Moves outside ESPERA are discarded.
- States, codes and transitions:
  - INICIAL (0): idle. iniciar=1 → PREPARACAO.
  - PREPARACAO (1): clear address and chaves register; latch limite → ESPERA.
  - ESPERA (2): wait for a move. Move → REGISTRA.
  - REGISTRA (4): load chaves into the register at the end of this cycle → COMPARA.
  - COMPARA (5):
    - if !db_igual → FIM_ERRO;
    - else if addr == latched limite → FIM_ACERTO;
    - else → PROXIMO.
  - PROXIMO (6): address +1 → ESPERA.
  - FIM_ACERTO (10): pronto=1, acertou=1.
  - FIM_ERRO (14): pronto=1, errou=1.
  - From either FIM state, iniciar=1 → PREPARACAO.
  - Any other code (illegal) → INICIAL.
- Outputs are Moore-decoded from state and held for the whole FIM state. pronto, acertou and errou are 0 in every other state.
- Latency: iniciar sampled in cycle n gives ESPERA at n+2. A move detected in cycle m gives COMPARA at m+2 and either a FIM state at m+3 or ESPERA again at m+4.
- Address stops at the latched limite and never exceeds it. limite = DEPTH-1 uses the full ROM without wrap. limite = 0 is a one-move game.
- A limite change mid-game has no effect until the next PREPARACAO.
- iniciar held high during FIM restarts the game immediately. iniciar is ignored in all other states.
- Reset asserted mid-operation aborts immediately to INICIAL with all outputs at their reset values.

Optional Feature:
- Macro: CIRCUITO_JOGO_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on entry to ESPERA and increments each cycle in ESPERA.
  - When it reaches TIMEOUT_CYCLES-1 with no move, the next state is FIM_ERRO and db_timeout=1, held through FIM_ERRO.
  - A move in the same cycle as the timeout wins (→ REGISTRA).
  - db_timeout clears on PREPARACAO or reset.
- Not defined: no counter is built; db_timeout is tied to 0; ESPERA waits forever.

Test Plan:
1. Reset low for 2 cycles, then high → db_estado=0, pronto=acertou=errou=0, db_contagem=0, db_memoria=1.
2. limite=3, pulse iniciar, play chaves 1, 2, 4, 8 with one jogada pulse each → FIM_ACERTO (db_estado=10), pronto=1, acertou=1, db_contagem=3.
3. limite=3, play 1 then 4 → FIM_ERRO after the second move, errou=1, db_contagem=1, db_chaves=4, db_memoria=2.
4. limite=15, 16 correct moves (1, 2, 4, 8 repeating) → acertou=1, db_contagem=15. Holding jogada high for 5 cycles counts as one move only.
5. Mid-game (db_contagem=2), drive reset=0 asynchronously between clock edges → outputs clear immediately; after release, iniciar restarts at address 0.
6. With CIRCUITO_JOGO_TIMEOUT_EN and TIMEOUT_CYCLES=8: enter ESPERA and give no move → FIM_ERRO 8 cycles later, errou=1, db_timeout=1. Without the macro, db_timeout stays 0 and the state stays 2.
